// File: rtl/l1_instr_ctrl.sv
// l1_instr_ctrl: tag/valid store and fetch/refill sequencer for a 64x128-bit L1 instruction array
module l1_instr_ctrl #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6,
    parameter int LINE_W = 128,
    parameter int TAG_W  = ADDR_W - IDX_W - 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_instr_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_valid_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              dat_we_o,
    output logic              dat_we_next_o,
    output logic [IDX_W-1:0]  dat_addr_o,
    output logic [LINE_W-1:0] dat_wdata_o,
    input  logic [LINE_W-1:0] dat_rdata_i,
    input  logic [15:0]       dat_next_i
);
    localparam int LINES = 1 << IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_CUR, MISS_NXT, REREAD, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q [LINES];
    logic              tag_we;
    logic [IDX_W-1:0]  tag_widx;
    logic [TAG_W-1:0]  tag_wdata;

    logic [2:0]        hw;
    logic [IDX_W-1:0]  idx, nidx;
    logic [TAG_W-1:0]  tag, ntag;
    logic              span, cur_hit, nxt_hit;
    logic [LINE_W+15:0] ext;

    assign hw      = addr_q[3:1];
    assign idx     = addr_q[IDX_W+3:4];
    assign tag     = addr_q[ADDR_W-1:IDX_W+4];
    assign nidx    = idx + 1'b1;
    assign ntag    = &idx ? tag + 1'b1 : tag;
    assign span    = &hw;
    assign cur_hit = valid_q[idx] && tag_q[idx] == tag;
    assign nxt_hit = valid_q[nidx] && tag_q[nidx] == ntag;
    // the next line's low halfword sits just above the current line, so one slice covers the spanning case
    assign ext     = {dat_next_i, dat_rdata_i};

    // next-state, valid-bit updates and all controller outputs
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        valid_d       = valid_q;
        tag_we        = 1'b0;
        tag_widx      = idx;
        tag_wdata     = tag;
        req_ready_o   = 1'b0;
        rsp_valid_o   = 1'b0;
        rsp_instr_o   = '0;
        mem_req_o     = 1'b0;
        mem_addr_o    = '0;
        dat_we_o      = 1'b0;
        dat_we_next_o = 1'b0;
        dat_addr_o    = idx;
        dat_wdata_o   = '0;
        case (state_q)
            IDLE: begin
                req_ready_o = !flush_i;
                dat_addr_o  = req_valid_i ? req_addr_i[IDX_W+3:4] : '0;
                if (flush_i) valid_d = '0;
                else if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: state_d = !cur_hit ? MISS_CUR : (span && !nxt_hit) ? MISS_NXT : RESP;
            MISS_CUR: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {tag, idx, 4'b0};
                if (mem_valid_i) begin
                    dat_we_o     = 1'b1;
                    dat_wdata_o  = mem_data_i;
                    tag_we       = 1'b1;
                    valid_d[idx] = 1'b1;
                    state_d      = (span && !nxt_hit) ? MISS_NXT : REREAD;
                end
            end
            MISS_NXT: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {ntag, nidx, 4'b0};
                tag_widx   = nidx;
                tag_wdata  = ntag;
                if (mem_valid_i) begin
                    dat_we_o      = 1'b1;
                    dat_we_next_o = 1'b1;
                    dat_wdata_o   = mem_data_i;
                    tag_we        = 1'b1;
                    valid_d[nidx] = 1'b1;
                    state_d       = REREAD;
                end
            end
            REREAD: state_d = RESP;
            RESP: begin
                rsp_valid_o = 1'b1;
                rsp_instr_o = ext[{1'b0, hw, 4'b0} +: 32];
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, latched request address and valid bits
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    // tag store needs no reset: entries are qualified by their valid bit
    always_ff @(posedge clk_i) begin
        if (tag_we) tag_q[tag_widx] <= tag_wdata;
    end
endmodule

// File: tb/tb_l1_instr_ctrl.sv
// tb_l1_instr_ctrl: random and directed fetches checked against a direct-mapped cache model over a flat memory
module tb_l1_instr_ctrl;
    logic         clk_i = 0, rst_ni = 0, req_valid_i = 0, rsp_ready_i = 0, flush_i = 0, mem_valid_i = 0;
    logic [31:0]  req_addr_i = '0;
    logic [127:0] mem_data_i = '0;
    logic [127:0] dat_rdata_i = '0;
    logic [15:0]  dat_next_i = '0;
    logic         req_ready_o, rsp_valid_o, mem_req_o, dat_we_o, dat_we_next_o;
    logic [31:0]  rsp_instr_o, mem_addr_o;
    logic [5:0]   dat_addr_o;
    logic [127:0] dat_wdata_o;

    int n_run = 0, n_fail = 0;
    logic [31:0]  cached [int];
    logic [127:0] arr [64];

    l1_instr_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_instr_o(rsp_instr_o), .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i), .dat_we_o(dat_we_o),
        .dat_we_next_o(dat_we_next_o), .dat_addr_o(dat_addr_o), .dat_wdata_o(dat_wdata_o),
        .dat_rdata_i(dat_rdata_i), .dat_next_i(dat_next_i)
    );

    always #5 clk_i = ~clk_i;

    // read-first data array with registered read and a next-line port
    always @(posedge clk_i) begin
        dat_rdata_i <= arr[dat_addr_o];
        dat_next_i  <= arr[dat_addr_o + 6'd1][15:0];
        if (dat_we_o) arr[dat_we_next_o ? dat_addr_o + 6'd1 : dat_addr_o] <= dat_wdata_o;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] hword(input logic [31:0] b);
        logic [31:0] h;
        h = (b >> 1) * 32'h9E3779B1;
        return h[28:13];
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] la);
        logic [127:0] l;
        for (int k = 0; k < 8; k++) l[16*k +: 16] = hword({la[31:4], 4'b0} + 32'(2*k));
        return l;
    endfunction

    function automatic bit present(input logic [31:0] la);
        int i;
        i = int'(la[9:4]);
        return cached.exists(i) && cached[i] == la;
    endfunction

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 0; req_valid_i = 0; mem_valid_i = 0; rsp_ready_i = 0; flush_i = 0;
        @(negedge clk_i);
        rst_ni = 1;
        cached.delete();
    endtask

    task automatic fetch(input logic [31:0] a, input int hold);
        logic [31:0] la0, la1, a2, ea, exp_i;
        logic [31:0] exp_q[$];
        bit span;
        int lat, guard;
        la0 = {a[31:4], 4'b0};
        la1 = la0 + 32'h10;
        a2 = {a[31:1], 1'b0};
        span = a[3:1] == 3'd7;
        exp_i = {hword(a2 + 32'd2), hword(a2)};
        if (!present(la0)) exp_q.push_back(la0);
        if (span && !present(la1)) exp_q.push_back(la1);
        @(negedge clk_i);
        req_valid_i = 1; req_addr_i = a;
        #1 check("req_ready", req_ready_o, 1);
        @(posedge clk_i);
        lat = 1;
        #1 req_valid_i = 0;
        guard = 0;
        while (guard < 80) begin
            guard++;
            @(negedge clk_i);
            #1;
            if (rsp_valid_o) break;
            if (mem_req_o) begin
                ea = exp_q.size() != 0 ? exp_q.pop_front() : 32'hFFFF_FFFF;
                check("mem_addr", mem_addr_o, ea);
                repeat ($urandom_range(0, 2)) @(negedge clk_i);
                #1 check("mem_addr_hold", mem_addr_o, ea);
                mem_valid_i = 1; mem_data_i = mem_line(mem_addr_o);
                #1;
                check("dat_we", dat_we_o, 1);
                check("dat_we_next", dat_we_next_o, span && ea == la1);
                check("dat_addr", dat_addr_o, a[9:4]);
                check("dat_wdata", dat_wdata_o, mem_line(ea));
                @(posedge clk_i);
                lat = 1;
                #1 mem_valid_i = 0; mem_data_i = '0;
            end else begin
                @(posedge clk_i);
                lat++;
            end
        end
        check("rsp_valid", rsp_valid_o, 1);
        if (!rsp_valid_o) begin
            do_reset();
            return;
        end
        check("latency", lat, 2);
        check("refills_left", exp_q.size(), 0);
        check("instr", rsp_instr_o, exp_i);
        check("ready_in_resp", req_ready_o, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i);
            #1;
            check("hold_valid", rsp_valid_o, 1);
            check("hold_instr", rsp_instr_o, exp_i);
            check("hold_ready", req_ready_o, 0);
        end
        rsp_ready_i = 1;
        @(posedge clk_i);
        #1 rsp_ready_i = 0;
        check("rsp_drop", rsp_valid_o, 0);
        check("back_idle", req_ready_o, 1);
        cached[int'(la0[9:4])] = la0;
        if (span) cached[int'(la1[9:4])] = la1;
    endtask

    task automatic flush_with_req(input logic [31:0] a);
        @(negedge clk_i);
        flush_i = 1; req_valid_i = 1; req_addr_i = a;
        @(posedge clk_i);
        #1 flush_i = 0; req_valid_i = 0;
        @(negedge clk_i);
        #1;
        check("flush_noacc", req_ready_o, 1);
        check("flush_nomem", mem_req_o, 0);
        cached.delete();
    endtask

    initial begin
        logic [31:0] a;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_ready", req_ready_o, 1);
        check("rst_rsp", rsp_valid_o, 0);
        check("rst_mem", mem_req_o, 0);
        check("rst_we", dat_we_o, 0);
        check("rst_instr", rsp_instr_o, 0);
        rst_ni = 1;
        fetch(32'h0000_0040, 0);
        fetch(32'h0000_0040, 5);
        flush_with_req(32'h0000_0040);
        fetch(32'h0000_0040, 0);
        flush_with_req(32'h0000_0000);
        fetch(32'h0000_004E, 1);
        fetch(32'h0000_03FE, 0);
        fetch(32'h0000_0400, 0);
        fetch(32'h0000_1040, 0);
        fetch(32'h0000_0040, 0);
        // reset while a refill is outstanding
        @(negedge clk_i);
        req_valid_i = 1; req_addr_i = 32'h0000_2340;
        @(posedge clk_i);
        #1 req_valid_i = 0;
        for (int i = 0; i < 10 && !mem_req_o; i++) @(negedge clk_i);
        #1 check("rst_wait_req", mem_req_o, 1);
        rst_ni = 0;
        #1;
        check("rst_mid_mem", mem_req_o, 0);
        check("rst_mid_ready", req_ready_o, 1);
        mem_valid_i = 1; mem_data_i = mem_line(32'h0000_2340);
        #1 check("rst_mid_we", dat_we_o, 0);
        @(posedge clk_i);
        #1 rst_ni = 1;
        @(negedge clk_i);
        #1 check("late_we", dat_we_o, 0);
        mem_valid_i = 0; mem_data_i = '0;
        cached.delete();
        fetch(32'h0000_0040, 0);
        repeat (200) begin
            if ($urandom_range(0, 19) == 0) begin
                @(negedge clk_i);
                flush_i = 1;
                @(negedge clk_i);
                flush_i = 0;
                cached.delete();
            end
            a = $urandom_range(0, 32'h1FFF);
            a[0] = 1'b0;
            if ($urandom_range(0, 3) == 0) a[3:1] = 3'd7;
            if ($urandom_range(0, 7) == 0) a[9:4] = 6'd63;
            fetch(a, int'($urandom_range(0, 2)));
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
